// File: rtl/lsu_mem_initiator_pkg.sv
// Shared types and constants for the LSU data-memory initiator: FSM states,
// RV32I load/store width codes, sign-mask fields and the default wait timeout.
package lsu_mem_initiator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_RESP    = 3'd4
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] MASK_BYTE = 3'b001;
  localparam logic [2:0] MASK_HALF = 3'b011;
  localparam logic [2:0] MASK_WORD = 3'b111;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

  // Clears the low address bits that a halfword or word access cannot use.
  function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic [1:0] size);
    logic [31:0] res;
    case (size)
      SIZE_HALF: res = {addr[31:1], 1'b0};
      SIZE_WORD: res = {addr[31:2], 2'b00};
      default:   res = addr;
    endcase
    return res;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    logic res;
    case (size)
      SIZE_HALF: res = addr_lo[0];
      SIZE_WORD: res = (addr_lo != 2'b00);
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Request/response handshake and data-memory bundle for lsu_mem_initiator.
// master = the initiator itself; slave = requester plus memory.
interface lsu_mem_initiator_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_sign_mask;
  logic              mem_read;
  logic              mem_write;
  logic              mem_stall;
  logic [31:0]       mem_rdata;

  modport master (
    input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
    input  mem_stall, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata, mem_sign_mask, mem_read, mem_write
  );

  modport slave (
    output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
    output mem_stall, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wdata, mem_sign_mask, mem_read, mem_write
  );
endinterface

// File: rtl/lsu_mask_decode.sv
// Combinational funct3 decode: {signed, width} memory sign mask, legality of the
// load/store/funct3 combination, and access size for address alignment.
module lsu_mask_decode
  import lsu_mem_initiator_pkg::*;
(
  input  logic       load,
  input  logic       store,
  input  logic [2:0] funct3,
  output logic [3:0] sign_mask,
  output logic       legal,
  output logic [1:0] size
);

  assign size = funct3[1:0];

  // Mask and legality lookup; unsigned variants exist only for loads.
  always_comb begin
    sign_mask = 4'b0000;
    legal     = 1'b0;
    if (load && !store) begin
      case (funct3)
        F3_B:    begin sign_mask = {1'b1, MASK_BYTE}; legal = 1'b1; end
        F3_H:    begin sign_mask = {1'b1, MASK_HALF}; legal = 1'b1; end
        F3_W:    begin sign_mask = {1'b1, MASK_WORD}; legal = 1'b1; end
        F3_BU:   begin sign_mask = {1'b0, MASK_BYTE}; legal = 1'b1; end
        F3_HU:   begin sign_mask = {1'b0, MASK_HALF}; legal = 1'b1; end
        default: begin sign_mask = 4'b0000;           legal = 1'b0; end
      endcase
    end else if (store && !load) begin
      case (funct3)
        F3_B:    begin sign_mask = {1'b0, MASK_BYTE}; legal = 1'b1; end
        F3_H:    begin sign_mask = {1'b0, MASK_HALF}; legal = 1'b1; end
        F3_W:    begin sign_mask = {1'b0, MASK_WORD}; legal = 1'b1; end
        default: begin sign_mask = 4'b0000;           legal = 1'b0; end
      endcase
    end else begin
      sign_mask = 4'b0000;
      legal     = 1'b0;
    end
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// LSU data-memory initiator: one load/store at a time over a stall-handshake memory.
// Define MISALIGN_TRAP_EN to reject misaligned halfword/word accesses with resp_err.
module lsu_mem_initiator
  import lsu_mem_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int ADDR_W         = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  lsu_mem_initiator_if.master bus
);

  localparam logic [4:0] TIMEOUT_LIMIT = 5'(TIMEOUT_CYCLES);

  lsu_state_e        state_q, state_d;
  logic [4:0]        wait_cnt_q, wait_cnt_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_sign_mask_q, mem_sign_mask_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              is_load_q, is_load_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic [ADDR_W-1:0] req_addr_s;
  logic [31:0]       req_addr32_s;
  logic [3:0]        dec_mask_s;
  logic              dec_legal_s;
  logic [1:0]        dec_size_s;
  logic              reject_s;
  logic              accept_s;
  logic [4:0]        wait_inc_s;
  logic              timeout_s;

  lsu_mask_decode u_mask_decode (
    .load      (bus.req_load),
    .store     (bus.req_store),
    .funct3    (bus.req_funct3),
    .sign_mask (dec_mask_s),
    .legal     (dec_legal_s),
    .size      (dec_size_s)
  );

  assign req_addr_s   = bus.req_addr;
  assign req_addr32_s = 32'(req_addr_s);
  // Requests with neither load nor store are not accepted at all.
  assign accept_s     = bus.req_valid && req_ready_q && (bus.req_load || bus.req_store);
  assign wait_inc_s   = wait_cnt_q + 5'd1;
  assign timeout_s    = (wait_inc_s == TIMEOUT_LIMIT);

`ifdef MISALIGN_TRAP_EN
  assign reject_s = !dec_legal_s || is_misaligned(req_addr32_s[1:0], dec_size_s);
`else
  assign reject_s = !dec_legal_s;
`endif

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_sign_mask_d = mem_sign_mask_q;
    is_load_d       = is_load_q;
    resp_rdata_d    = resp_rdata_q;
    resp_err_d      = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          mem_addr_d      = align_addr(req_addr32_s, dec_size_s);
          mem_wdata_d     = bus.req_wdata;
          mem_sign_mask_d = dec_mask_s;
          is_load_d       = bus.req_load;
          resp_rdata_d    = 32'd0;
          if (reject_s) begin
            state_d    = ST_RESP;
            resp_err_d = 1'b1;
          end else begin
            state_d    = ST_ISSUE;
            resp_err_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d    = ST_WAIT_HI;
        wait_cnt_d = 5'd0;
      end
      ST_WAIT_HI: begin
        if (bus.mem_stall) begin
          state_d    = ST_WAIT_LO;
          wait_cnt_d = 5'd0;
        end else if (timeout_s) begin
          state_d      = ST_RESP;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'd0;
        end else begin
          wait_cnt_d = wait_inc_s;
        end
      end
      ST_WAIT_LO: begin
        if (!bus.mem_stall) begin
          state_d      = ST_RESP;
          resp_err_d   = 1'b0;
          resp_rdata_d = bus.mem_rdata;
        end else if (timeout_s) begin
          state_d      = ST_RESP;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'd0;
        end else begin
          wait_cnt_d = wait_inc_s;
        end
      end
      ST_RESP: begin
        state_d    = ST_IDLE;
        resp_err_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Strobes are registered from the next state so they line up with it.
    mem_read_d   = (state_d == ST_ISSUE) && is_load_d;
    mem_write_d  = (state_d == ST_ISSUE) && !is_load_d;
    resp_valid_d = (state_d == ST_RESP);
    req_ready_d  = (state_d == ST_IDLE);
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      wait_cnt_q      <= 5'd0;
      mem_addr_q      <= 32'd0;
      mem_wdata_q     <= 32'd0;
      mem_sign_mask_q <= 4'b0000;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      is_load_q       <= 1'b0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_err_q      <= 1'b0;
      resp_rdata_q    <= 32'd0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_sign_mask_q <= mem_sign_mask_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      is_load_q       <= is_load_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_err_q      <= resp_err_d;
      resp_rdata_q    <= resp_rdata_d;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_err      = resp_err_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_sign_mask = mem_sign_mask_q;
  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: hand-computed vectors, one checking task.
module tb_lsu_mem_initiator;

  localparam int TMO = 16;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  int          lat, rd_cnt, wr_cnt, both_cnt, resp_cnt;
  logic [31:0] t_rdata, t_addr, t_wdata;
  logic [3:0]  t_mask;
  logic        t_err, t_stable, t_after_ok;

  lsu_mem_initiator_if #(.ADDR_W(32)) bus ();

  lsu_mem_initiator #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request at a negedge and follows it to resp_valid. The memory
  // stall is high for hi_len cycles starting hi_start cycles after acceptance.
  task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int hi_start, input int hi_len);
    int  cyc;
    bit  done;
    bus.req_valid  = 1'b1;
    bus.req_load   = ld;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.mem_rdata  = rdata;
    bus.mem_stall  = 1'b0;
    lat = -1; rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
    t_stable = 1'b1; t_err = 1'bx; t_rdata = 32'hx;
    done = 1'b0; cyc = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.req_valid = 1'b0;
        t_addr  = bus.mem_addr;
        t_wdata = bus.mem_wdata;
        t_mask  = bus.mem_sign_mask;
      end else if (bus.mem_addr !== t_addr || bus.mem_wdata !== t_wdata ||
                   bus.mem_sign_mask !== t_mask) begin
        t_stable = 1'b0;
      end
      if (bus.mem_read === 1'b1) rd_cnt++;
      if (bus.mem_write === 1'b1) wr_cnt++;
      if (bus.mem_read === 1'b1 && bus.mem_write === 1'b1) both_cnt++;
      bus.mem_stall = (cyc >= hi_start) && (cyc < hi_start + hi_len);
      if (bus.resp_valid === 1'b1) begin
        lat     = cyc;
        t_rdata = bus.resp_rdata;
        t_err   = bus.resp_err;
        done    = 1'b1;
      end
    end
    @(negedge clk);
    bus.mem_stall = 1'b0;
    t_after_ok = (bus.resp_valid === 1'b0) && (bus.req_ready === 1'b1) && (bus.mem_read === 1'b0);
  endtask

  task automatic check_txn(input string tag, input int exp_lat, input int exp_rd,
                           input int exp_wr, input logic exp_err);
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_rd"}, rd_cnt, exp_rd);
    check_eq({tag, "_wr"}, wr_cnt, exp_wr);
    check_eq({tag, "_err"}, 32'(t_err), 32'(exp_err));
    check_eq({tag, "_rdwr_excl"}, both_cnt, 32'd0);
    check_eq({tag, "_hold"}, 32'(t_stable), 32'd1);
    check_eq({tag, "_after"}, 32'(t_after_ok), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_store = 1'b0;
    bus.req_funct3 = 3'b000; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    bus.mem_stall = 1'b0; bus.mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_ctrl", 32'({bus.req_ready, bus.mem_read, bus.mem_write, bus.resp_valid, bus.resp_err}), 32'h10);
    check_eq("rst_addr", bus.mem_addr, 32'd0);
    check_eq("rst_wdata", bus.mem_wdata, 32'd0);
    check_eq("rst_rdata", bus.resp_rdata, 32'd0);
    check_eq("rst_mask", 32'(bus.mem_sign_mask), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_ready", 32'(bus.req_ready), 32'd1);

    // LB, minimum latency: stall high only in the cycle after ISSUE
    run_txn(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'hFFFF_FF80, 2, 1);
    check_txn("lb", 4, 1, 0, 1'b0);
    check_eq("lb_mask", 32'(t_mask), 32'h9);
    check_eq("lb_addr", t_addr, 32'h0000_1003);
    check_eq("lb_rdata", t_rdata, 32'hFFFF_FF80);

    run_txn(1'b0, 1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'd0, 2, 3);
    check_txn("sw", 6, 0, 1, 1'b0);
    check_eq("sw_wdata", t_wdata, 32'hDEAD_BEEF);
    check_eq("sw_mask", 32'(t_mask), 32'h7);
    check_eq("sw_addr", t_addr, 32'h0000_1004);

    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'd0, 32'h1122_3344, 2, 1);
`ifdef MISALIGN_TRAP_EN
    check_txn("lw_mis", 1, 0, 0, 1'b1);
    check_eq("lw_mis_rdata", t_rdata, 32'd0);
`else
    check_txn("lw_mis", 4, 1, 0, 1'b0);
    check_eq("lw_mis_addr", t_addr, 32'h0000_1000);
    check_eq("lw_mis_mask", 32'(t_mask), 32'hF);
    check_eq("lw_mis_rdata", t_rdata, 32'h1122_3344);
`endif

    run_txn(1'b0, 1'b1, 3'b001, 32'h0000_2001, 32'h0000_BEEF, 32'd0, 2, 1);
`ifdef MISALIGN_TRAP_EN
    check_txn("sh_mis", 1, 0, 0, 1'b1);
`else
    check_txn("sh_mis", 4, 0, 1, 1'b0);
    check_eq("sh_mis_addr", t_addr, 32'h0000_2000);
    check_eq("sh_mis_mask", 32'(t_mask), 32'h3);
`endif

    run_txn(1'b0, 1'b1, 3'b000, 32'h0000_2003, 32'h0000_00AB, 32'd0, 2, 1);
    check_txn("sb", 4, 0, 1, 1'b0);
    check_eq("sb_mask", 32'(t_mask), 32'h1);
    check_eq("sb_wdata", t_wdata, 32'h0000_00AB);

    run_txn(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'd0, 32'h0000_FFFE, 2, 2);
    check_txn("lhu", 5, 1, 0, 1'b0);
    check_eq("lhu_mask", 32'(t_mask), 32'h3);
    check_eq("lhu_rdata", t_rdata, 32'h0000_FFFE);

    // Illegal requests respond the cycle after acceptance with no memory cycle
    run_txn(1'b1, 1'b1, 3'b010, 32'h0000_1000, 32'd0, 32'h5555_5555, 2, 1);
    check_txn("ill_both", 1, 0, 0, 1'b1);
    check_eq("ill_both_rdata", t_rdata, 32'd0);
    run_txn(1'b1, 1'b0, 3'b011, 32'h0000_1000, 32'd0, 32'd0, 2, 1);
    check_txn("ill_ld_f3", 1, 0, 0, 1'b1);
    run_txn(1'b0, 1'b1, 3'b100, 32'h0000_1000, 32'h1, 32'd0, 2, 1);
    check_txn("ill_st_f3", 1, 0, 0, 1'b1);

    // Timeouts: WAIT_HI entered in cycle 2, WAIT_LO in cycle 3
    run_txn(1'b1, 1'b0, 3'b001, 32'h0000_1000, 32'd0, 32'h1234_5678, 100, 0);
    check_txn("tmo_hi", 2 + TMO, 1, 0, 1'b1);
    check_eq("tmo_hi_mask", 32'(t_mask), 32'hB);
    check_eq("tmo_hi_rdata", t_rdata, 32'd0);
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_1008, 32'd0, 32'hA5A5_A5A5, 2, 100);
    check_txn("tmo_lo", 3 + TMO, 1, 0, 1'b1);
    check_eq("tmo_lo_rdata", t_rdata, 32'd0);

    // Neither load nor store: ignored, ready stays high
    bus.req_valid = 1'b1; bus.req_load = 1'b0; bus.req_store = 1'b0;
    resp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.req_ready !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 ||
          bus.resp_valid !== 1'b0) resp_cnt++;
    end
    check_eq("none_ignored", resp_cnt, 32'd0);
    bus.req_valid = 1'b0;

    // Reset while in WAIT_LO drops the transaction
    bus.req_valid = 1'b1; bus.req_load = 1'b1; bus.req_store = 1'b0;
    bus.req_funct3 = 3'b010; bus.req_addr = 32'h0000_2000; bus.mem_rdata = 32'h55;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_eq("rmid_issue_rd", 32'(bus.mem_read), 32'd1);
    @(negedge clk);
    bus.mem_stall = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rmid_ctrl", 32'({bus.mem_read, bus.mem_write, bus.resp_valid, bus.resp_err}), 32'd0);
    check_eq("rmid_addr", bus.mem_addr, 32'd0);
    resp_cnt = 0;
    @(negedge clk);
    if (bus.resp_valid !== 1'b0) resp_cnt++;
    rst_n = 1'b1;
    bus.mem_stall = 1'b0;
    @(negedge clk);
    check_eq("rmid_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (bus.resp_valid !== 1'b0) resp_cnt++;
      @(negedge clk);
    end
    check_eq("rmid_no_resp", resp_cnt, 32'd0);

    run_txn(1'b1, 1'b0, 3'b100, 32'h0000_3001, 32'd0, 32'h0000_0080, 2, 1);
    check_txn("lbu", 4, 1, 0, 1'b0);
    check_eq("lbu_mask", 32'(t_mask), 32'h1);
    check_eq("lbu_addr", t_addr, 32'h0000_3001);
    check_eq("lbu_rdata", t_rdata, 32'h0000_0080);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
